// File: rtl/regfile_scoreboard_if.sv
// Bundles the register file's write, read, reserve and hazard signals.
// The master side is the controller; the slave side is the register file.
interface regfile_scoreboard_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr1;
    logic [AW-1:0]    rd_addr2;
    logic             rd_use1;
    logic             rd_use2;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic             hazard;
    logic [DEPTH-1:0] busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, rd_use1, rd_use2,
               rsv_en, rsv_addr,
        input  rd_data1, rd_data2, hazard, busy_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, rd_use1, rd_use2,
               rsv_en, rsv_addr,
        output rd_data1, rd_data2, hazard, busy_vec
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with hardwired-zero R0 and a per-register pending-write scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_scoreboard_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        FREE    = 1'b0,
        PENDING = 1'b1
    } busy_state_t;

    logic [WIDTH-1:0] r_regs  [DEPTH];
    busy_state_t      r_state [DEPTH];

    logic             w_wr_ok;
    logic             w_rsv_ok;
    logic [WIDTH-1:0] w_rd_data1;
    logic [WIDTH-1:0] w_rd_data2;
    logic             w_busy1;
    logic             w_busy2;

    assign w_wr_ok  = bus.wr_en  && (bus.wr_addr  != AW'(0));
    assign w_rsv_ok = bus.rsv_en && (bus.rsv_addr != AW'(0));

    // Reserve is applied after write so a same-address reserve leaves the register pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_regs[i]  <= '0;
                r_state[i] <= FREE;
            end
        end else begin
            if (w_wr_ok) begin
                r_regs[bus.wr_addr]  <= bus.wr_data;
                r_state[bus.wr_addr] <= FREE;
            end
            if (w_rsv_ok) begin
                r_state[bus.rsv_addr] <= PENDING;
            end
        end
    end

    always_comb begin
        w_rd_data1 = r_regs[bus.rd_addr1];
        w_rd_data2 = r_regs[bus.rd_addr2];
        w_busy1    = (r_state[bus.rd_addr1] == PENDING);
        w_busy2    = (r_state[bus.rd_addr2] == PENDING);
`ifdef REGFILE_BYPASS_EN
        // A matching write this cycle supplies the operand, so its producer is no longer outstanding.
        if (w_wr_ok && (bus.rd_addr1 == bus.wr_addr)) begin
            w_rd_data1 = bus.wr_data;
            w_busy1    = 1'b0;
        end
        if (w_wr_ok && (bus.rd_addr2 == bus.wr_addr)) begin
            w_rd_data2 = bus.wr_data;
            w_busy2    = 1'b0;
        end
`endif
    end

    assign bus.rd_data1 = w_rd_data1;
    assign bus.rd_data2 = w_rd_data2;
    assign bus.hazard   = (bus.rd_use1 && w_busy1) || (bus.rd_use2 && w_busy2);

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_busy
        assign bus.busy_vec[g] = (r_state[g] == PENDING);
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus randomized traffic
// checked against an array-based model; a second 16x32 instance covers parametrisation.
module tb_regfile_scoreboard;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    regfile_scoreboard_if #(.WIDTH(8),  .DEPTH(8))  ifc   ();
    regfile_scoreboard_if #(.WIDTH(16), .DEPTH(32)) ifc_w ();

    regfile_scoreboard #(.WIDTH(8),  .DEPTH(8))  dut   (.clk(clk), .rst(rst), .bus(ifc.slave));
    regfile_scoreboard #(.WIDTH(16), .DEPTH(32)) dut_w (.clk(clk), .rst(rst), .bus(ifc_w.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference state: register contents and pending flags.
    logic [7:0] m_regs [8];
    bit         m_busy [8];
    logic [7:0] last_rd1;
    logic [7:0] last_rd2;
    logic       last_hz;
    logic [7:0] last_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit fwd(input int a, input logic we, input logic [2:0] wa);
        return BYPASS && we && (wa != 3'd0) && (int'(wa) == a);
    endfunction

    function automatic logic [7:0] exp_rd(input int a, input logic we, input logic [2:0] wa,
                                          input logic [7:0] wd);
        if (fwd(a, we, wa)) return wd;
        if (a == 0) return 8'h00;
        return m_regs[a];
    endfunction

    function automatic bit exp_pending(input int a, input logic we, input logic [2:0] wa);
        return m_busy[a] && !fwd(a, we, wa);
    endfunction

    // Applies one cycle of inputs, checks the combinational view, then advances the model across the edge.
    task automatic cycle(input string tag, input logic r, input logic we, input logic [2:0] wa,
                         input logic [7:0] wd, input logic [2:0] a1, input logic [2:0] a2,
                         input logic u1, input logic u2, input logic re, input logic [2:0] ra);
        logic [7:0] ebusy;
        logic       ehz;
        rst          = r;
        ifc.wr_en    = we;
        ifc.wr_addr  = wa;
        ifc.wr_data  = wd;
        ifc.rd_addr1 = a1;
        ifc.rd_addr2 = a2;
        ifc.rd_use1  = u1;
        ifc.rd_use2  = u2;
        ifc.rsv_en   = re;
        ifc.rsv_addr = ra;
        @(negedge clk);
        ebusy = '0;
        for (int i = 1; i < 8; i++) ebusy[i] = m_busy[i];
        ehz = (u1 && exp_pending(int'(a1), we, wa)) || (u2 && exp_pending(int'(a2), we, wa));
        last_rd1  = ifc.rd_data1;
        last_rd2  = ifc.rd_data2;
        last_hz   = ifc.hazard;
        last_busy = ifc.busy_vec;
        chk({tag, "/rd_data1"}, 64'(ifc.rd_data1), 64'(exp_rd(int'(a1), we, wa, wd)));
        chk({tag, "/rd_data2"}, 64'(ifc.rd_data2), 64'(exp_rd(int'(a2), we, wa, wd)));
        chk({tag, "/hazard"},   64'(ifc.hazard),   64'(ehz));
        chk({tag, "/busy_vec"}, 64'(ifc.busy_vec), 64'(ebusy));
        if (!r) begin
            for (int i = 0; i < 8; i++) begin
                m_regs[i] = 8'h00;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && wa != 3'd0) begin
                m_regs[wa] = wd;
                m_busy[wa] = 1'b0;
            end
            if (re && ra != 3'd0) m_busy[ra] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wide();
        ifc_w.wr_en    = 1'b0;
        ifc_w.wr_addr  = '0;
        ifc_w.wr_data  = '0;
        ifc_w.rd_addr1 = '0;
        ifc_w.rd_addr2 = '0;
        ifc_w.rd_use1  = 1'b0;
        ifc_w.rd_use2  = 1'b0;
        ifc_w.rsv_en   = 1'b0;
        ifc_w.rsv_addr = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 8'h00;
            m_busy[i] = 1'b0;
        end
        rst          = 1'b0;
        ifc.wr_en    = 1'b0;
        ifc.wr_addr  = '0;
        ifc.wr_data  = '0;
        ifc.rd_addr1 = '0;
        ifc.rd_addr2 = '0;
        ifc.rd_use1  = 1'b0;
        ifc.rd_use2  = 1'b0;
        ifc.rsv_en   = 1'b0;
        ifc.rsv_addr = '0;
        idle_wide();
        @(posedge clk);
        #1;

        // Wide instance: 16-bit data, 32 registers.
        rst = 1'b1;
        ifc_w.wr_en   = 1'b1;
        ifc_w.wr_addr = 5'd31;
        ifc_w.wr_data = 16'hBEEF;
        @(posedge clk);
        #1;
        idle_wide();
        ifc_w.rd_addr1 = 5'd31;
        ifc_w.rd_addr2 = 5'd31;
        ifc_w.rsv_en   = 1'b1;
        ifc_w.rsv_addr = 5'd17;
        @(negedge clk);
        chk("wide/rd_data1", 64'(ifc_w.rd_data1), 64'h0000_BEEF);
        chk("wide/rd_data2", 64'(ifc_w.rd_data2), 64'h0000_BEEF);
        chk("wide/busy_pre", 64'(ifc_w.busy_vec), 64'h0);
        @(posedge clk);
        #1;
        idle_wide();
        ifc_w.rd_addr1 = 5'd17;
        ifc_w.rd_use1  = 1'b1;
        @(negedge clk);
        chk("wide/busy_vec", 64'(ifc_w.busy_vec), 64'h0002_0000);
        chk("wide/hazard",   64'(ifc_w.hazard),   64'h1);
        chk("wide/r0",       64'(ifc_w.rd_data2), 64'h0);
        @(posedge clk);
        #1;
        idle_wide();

        // Reset clears filled registers and a pending reservation.
        for (int i = 1; i < 8; i++)
            cycle("fill", 1, 1, 3'(i), 8'hA0 + 8'(i), 3'(i - 1), 3'(i), 0, 0, 0, 3'd0);
        cycle("rsv_r3", 1, 0, 3'd0, 8'h00, 3'd3, 3'd7, 1, 0, 1, 3'd3);
        cycle("in_reset", 0, 1, 3'd2, 8'h77, 3'd3, 3'd2, 1, 1, 1, 3'd5);
        chk("pre_reset/busy", 64'(last_busy), 64'h08);
        for (int i = 0; i < 8; i += 2) begin
            cycle("post_reset", 1, 0, 3'd0, 8'h00, 3'(i), 3'(i + 1), 1, 1, 0, 3'd0);
            chk("post_reset/rd1", 64'(last_rd1), 64'h0);
            chk("post_reset/rd2", 64'(last_rd2), 64'h0);
            chk("post_reset/hz",  64'(last_hz),  64'h0);
            chk("post_reset/bv",  64'(last_busy), 64'h0);
        end

        // Register 0 ignores writes and reservations.
        cycle("wr_r0",  1, 1, 3'd0, 8'hFF, 3'd0, 3'd0, 1, 1, 0, 3'd0);
        cycle("rsv_r0", 1, 0, 3'd0, 8'h00, 3'd0, 3'd0, 1, 1, 1, 3'd0);
        cycle("chk_r0", 1, 0, 3'd0, 8'h00, 3'd0, 3'd0, 1, 1, 0, 3'd0);
        chk("r0/data", 64'(last_rd1), 64'h0);
        chk("r0/busy", 64'(last_busy), 64'h0);

        // Read-after-write stall on R5, then the same with the operand unused.
        cycle("raw_rsv",   1, 0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 0, 1, 3'd5);
        cycle("raw_stall", 1, 0, 3'd0, 8'h00, 3'd5, 3'd0, 1, 0, 0, 3'd0);
        chk("raw/hazard_set", 64'(last_hz), 64'h1);
        cycle("raw_wr",    1, 1, 3'd5, 8'h3C, 3'd0, 3'd0, 0, 0, 0, 3'd0);
        cycle("raw_done",  1, 0, 3'd0, 8'h00, 3'd5, 3'd0, 1, 0, 0, 3'd0);
        chk("raw/hazard_clr", 64'(last_hz),  64'h0);
        chk("raw/data",       64'(last_rd1), 64'h3C);
        cycle("nouse_rsv", 1, 0, 3'd0, 8'h00, 3'd5, 3'd0, 0, 0, 1, 3'd5);
        cycle("nouse_rd",  1, 0, 3'd0, 8'h00, 3'd5, 3'd0, 0, 0, 0, 3'd0);
        chk("nouse/hazard", 64'(last_hz), 64'h0);
        cycle("nouse_wr",  1, 1, 3'd5, 8'h3D, 3'd5, 3'd0, 0, 0, 0, 3'd0);

        // Same-address write and reserve: data lands, register stays pending.
        cycle("race_rsv", 1, 0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 0, 1, 3'd2);
        cycle("race",     1, 1, 3'd2, 8'h55, 3'd0, 3'd0, 0, 0, 1, 3'd2);
        cycle("race_chk", 1, 0, 3'd0, 8'h00, 3'd2, 3'd0, 0, 0, 0, 3'd0);
        chk("race/data", 64'(last_rd1), 64'h55);
        chk("race/busy", 64'(last_busy[2]), 64'h1);

        // Write to a busy R4 while port 2 reads it.
        cycle("byp_init", 1, 1, 3'd4, 8'h11, 3'd0, 3'd0, 0, 0, 0, 3'd0);
        cycle("byp_rsv",  1, 0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 0, 1, 3'd4);
        cycle("byp_wr",   1, 1, 3'd4, 8'h9E, 3'd0, 3'd4, 0, 1, 0, 3'd0);
        chk("byp/same_data", 64'(last_rd2), BYPASS ? 64'h9E : 64'h11);
        chk("byp/same_hz",   64'(last_hz),  BYPASS ? 64'h0  : 64'h1);
        cycle("byp_next", 1, 0, 3'd0, 8'h00, 3'd0, 3'd4, 0, 1, 0, 3'd0);
        chk("byp/next_data", 64'(last_rd2), 64'h9E);
        chk("byp/next_hz",   64'(last_hz),  64'h0);

        // Randomized traffic, including occasional mid-run resets.
        for (int n = 0; n < 400; n++) begin
            cycle("rand", logic'($urandom_range(31) != 0), logic'($urandom_range(1)),
                  3'($urandom_range(7)), 8'($urandom),
                  3'($urandom_range(7)), 3'($urandom_range(7)),
                  logic'($urandom_range(1)), logic'($urandom_range(1)),
                  logic'($urandom_range(9) < 4), 3'($urandom_range(7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
